// File: rtl/pll_clk_manager.sv
// PLL reset sequencer, lock qualifier and programmable clock-enable strobes.
// Optional lock glitch filter: define PLL_CLK_MANAGER_LOCK_FILTER_EN.
module pll_clk_manager #(
  parameter int NUM_CH             = 4,
  parameter int DIV_W              = 16,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 4096,
  parameter int LOCK_STABLE_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    PLL_LOCK,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  output logic                    PLL_RESETB,
  output logic                    SYS_RESETN,
  output logic [NUM_CH-1:0]       CLK_EN,
  output logic [1:0]              STATE,
  output logic [7:0]              LOSS_COUNT,
  output logic [7:0]              RETRY_COUNT
);

  localparam int TM0 =
    (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
    PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX =
    (TM0 > LOCK_STABLE_CYCLES) ?
    TM0 : LOCK_STABLE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_WAIT = 2'd1,
    S_STAB = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t        st, st_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          s1, lock_s, lock_q;
  logic          retry_inc, loss_inc;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1     <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      s1     <= PLL_LOCK;
      lock_s <= s1;
    end
  end

`ifdef PLL_CLK_MANAGER_LOCK_FILTER_EN
  // lq_r holds lock_q high until lock_s has been low 4 cycles
  logic [1:0] zc;
  logic       lq_r;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      zc   <= 2'd0;
      lq_r <= 1'b0;
    end else if (lock_s) begin
      zc   <= 2'd0;
      lq_r <= 1'b1;
    end else if (zc == 2'd3) begin
      lq_r <= 1'b0;
    end else begin
      zc <= zc + 2'd1;
    end
  end

  assign lock_q = lock_s | lq_r;
`else
  assign lock_q = lock_s;
`endif

  always_comb begin
    st_n      = st;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    unique case (st)
      S_RST: begin
        if (tcnt == TW'(PLL_RST_CYCLES - 1))
          st_n = S_WAIT;
      end
      S_WAIT: begin
        if (lock_q) begin
          st_n = S_STAB;
        end else if (tcnt == TW'(LOCK_TIMEOUT - 1)) begin
          st_n      = S_RST;
          retry_inc = 1'b1;
        end
      end
      S_STAB: begin
        if (!lock_q)
          st_n = S_WAIT;
        else if (tcnt == TW'(LOCK_STABLE_CYCLES - 1))
          st_n = S_RUN;
      end
      S_RUN: begin
        if (!lock_q) begin
          st_n     = S_RST;
          loss_inc = 1'b1;
        end
      end
    endcase
    if (st_n != st)
      tcnt_n = '0;
    else if (st == S_RUN)
      tcnt_n = tcnt;
    else
      tcnt_n = tcnt + TW'(1);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st          <= S_RST;
      tcnt        <= '0;
      PLL_RESETB  <= 1'b0;
      SYS_RESETN  <= 1'b0;
      LOSS_COUNT  <= 8'd0;
      RETRY_COUNT <= 8'd0;
    end else begin
      st         <= st_n;
      tcnt       <= tcnt_n;
      PLL_RESETB <= (st_n != S_RST);
      SYS_RESETN <= (st_n == S_RUN);
      if (retry_inc && RETRY_COUNT != 8'hff)
        RETRY_COUNT <= RETRY_COUNT + 8'd1;
      if (loss_inc && LOSS_COUNT != 8'hff)
        LOSS_COUNT <= LOSS_COUNT + 8'd1;
    end
  end

  assign STATE = st;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] dv;
    logic [DIV_W-1:0] rld;

    assign dv  = DIV[g*DIV_W +: DIV_W];
    assign rld = (dv == '0) ? '0 : dv - DIV_W'(1);

    // DIV is only looked at on reload, so periods never truncate
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        cnt       <= '0;
        CLK_EN[g] <= 1'b0;
      end else if (st_n != S_RUN) begin
        cnt       <= '0;
        CLK_EN[g] <= 1'b0;
      end else if (cnt == '0) begin
        cnt       <= rld;
        CLK_EN[g] <= 1'b1;
      end else begin
        cnt       <= cnt - DIV_W'(1);
        CLK_EN[g] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pll_clk_manager.sv
// Directed bench for pll_clk_manager with small timing parameters.
// Cycle offsets in comments count posedges from the named event.
module tb_pll_clk_manager;

`ifdef PLL_CLK_MANAGER_LOCK_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock;
  logic [31:0] div;
  logic        resetb;
  logic        sysr;
  logic [1:0]  en;
  logic [1:0]  st;
  logic [7:0]  loss;
  logic [7:0]  retry;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pll_clk_manager #(
    .NUM_CH(2),
    .DIV_W(16),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT(32),
    .LOCK_STABLE_CYCLES(8)
  ) dut (
    .CLK(clk),
    .RESET(rst_n),
    .PLL_LOCK(lock),
    .DIV(div),
    .PLL_RESETB(resetb),
    .SYS_RESETN(sysr),
    .CLK_EN(en),
    .STATE(st),
    .LOSS_COUNT(loss),
    .RETRY_COUNT(retry)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".state"}, 32'(st), 0);
    chk({tag, ".resetb"}, 32'(resetb), 0);
    chk({tag, ".sysr"}, 32'(sysr), 0);
    chk({tag, ".en"}, 32'(en), 0);
    chk({tag, ".loss"}, 32'(loss), 0);
    chk({tag, ".retry"}, 32'(retry), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    lock  = 1'b0;
    div   = {16'd1, 16'd3};
    tick(3);
    chk_rst("reset");

    // power-up, no lock
    rst_n = 1'b1;
    tick(3);
    chk("pu3.state", 32'(st), 0);
    chk("pu3.resetb", 32'(resetb), 0);
    tick(1);
    chk("pu4.state", 32'(st), 1);
    chk("pu4.resetb", 32'(resetb), 1);
    chk("pu4.sysr", 32'(sysr), 0);
    chk("pu4.en", 32'(en), 0);

    // timeouts every 36 cycles (4 reset + 32 wait)
    tick(31);
    chk("to1_pre.state", 32'(st), 1);
    chk("to1_pre.retry", 32'(retry), 0);
    tick(1);
    chk("to1.state", 32'(st), 0);
    chk("to1.resetb", 32'(resetb), 0);
    chk("to1.retry", 32'(retry), 1);
    tick(4);
    chk("to1_w.state", 32'(st), 1);
    chk("to1_w.resetb", 32'(resetb), 1);
    tick(32);
    chk("to2.state", 32'(st), 0);
    chk("to2.retry", 32'(retry), 2);
    tick(4);
    chk("to2_w.state", 32'(st), 1);
    tick(32);
    chk("to3.retry", 32'(retry), 3);
    tick(4);
    chk("to3_w.state", 32'(st), 1);

    // lock rises at WAIT_LOCK tcnt 5
    tick(5);
    lock = 1'b1;
    tick(2);
    chk("lk7.state", 32'(st), 1);
    tick(1);
    chk("lk8.state", 32'(st), 2);
    tick(7);
    chk("lk15.state", 32'(st), 2);
    chk("lk15.sysr", 32'(sysr), 0);
    tick(1);
    chk("run0.state", 32'(st), 3);
    chk("run0.sysr", 32'(sysr), 1);
    chk("run0.resetb", 32'(resetb), 1);
    chk("run0.en", 32'(en), 2'b11);
    tick(1);
    chk("run1.en", 32'(en), 2'b10);
    tick(1);
    chk("run2.en", 32'(en), 2'b10);
    tick(1);
    chk("run3.en", 32'(en), 2'b11);
    tick(3);
    chk("run6.en", 32'(en), 2'b11);

    // lock loss in RUN for 10 cycles
    lock = 1'b0;
    tick(LAT - 1);
    chk("loss_pre.state", 32'(st), 3);
    chk("loss_pre.sysr", 32'(sysr), 1);
    tick(1);
    chk("loss.state", 32'(st), 0);
    chk("loss.sysr", 32'(sysr), 0);
    chk("loss.en", 32'(en), 0);
    chk("loss.resetb", 32'(resetb), 0);
    chk("loss.count", 32'(loss), 1);
    tick(10 - LAT);
    lock = 1'b1;
    tick(3);
    chk("relock.state", 32'(st), 2);
    chk("relock.retry", 32'(retry), 3);

    // one-cycle drop in STABLE
    tick(2);
    lock = 1'b0;
    tick(1);
    lock = 1'b1;
`ifdef PLL_CLK_MANAGER_LOCK_FILTER_EN
    tick(2);
    chk("drop5.state", 32'(st), 2);
    tick(2);
    chk("drop7.state", 32'(st), 2);
    tick(1);
    chk("drop8.state", 32'(st), 3);
`else
    tick(2);
    chk("drop5.state", 32'(st), 1);
    tick(1);
    chk("drop6.state", 32'(st), 2);
    tick(7);
    chk("drop13.state", 32'(st), 2);
    tick(1);
    chk("drop14.state", 32'(st), 3);
`endif

    // DIV[0] 3 -> 5 mid-period
    chk("dv0.en", 32'(en), 2'b11);
    tick(1);
    div[15:0] = 16'd5;
    chk("dv1.en", 32'(en), 2'b10);
    tick(2);
    chk("dv3.en", 32'(en), 2'b11);
    tick(2);
    chk("dv5.en", 32'(en), 2'b10);
    tick(2);
    chk("dv7.en", 32'(en), 2'b10);
    tick(1);
    chk("dv8.en", 32'(en), 2'b11);
    tick(5);
    chk("dv13.en", 32'(en), 2'b11);
    tick(1);
    chk("dv14.en", 32'(en), 2'b10);

`ifdef PLL_CLK_MANAGER_LOCK_FILTER_EN
    lock = 1'b0;
    tick(3);
    lock = 1'b1;
    tick(8);
    chk("glitch.state", 32'(st), 3);
    chk("glitch.sysr", 32'(sysr), 1);
`endif
    chk("pre_ar.state", 32'(st), 3);
    chk("pre_ar.loss", 32'(loss), 1);
    chk("pre_ar.retry", 32'(retry), 3);

    // async reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst("async");

    // retry saturation with lock held low
    lock = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(36 * 255 - 1);
    chk("sat254.retry", 32'(retry), 254);
    tick(1);
    chk("sat255.retry", 32'(retry), 255);
    tick(36 * 3);
    chk("sathold.retry", 32'(retry), 255);
    chk("sathold.state", 32'(st), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
